// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Adds synchronous flush and saturating stall/bubble performance counters.
module id_ex_skid_stage #(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_nop,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_nop,
   output logic [W-1:0]     out_data,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic         main_v, skid_v;
   logic         main_nop, skid_nop;
   logic [W-1:0] main_data, skid_data;

   logic         nxt_main_v, nxt_skid_v;
   logic         nxt_main_nop, nxt_skid_nop;
   logic [W-1:0] nxt_main_data, nxt_skid_data;

   logic accept, xfer;

   // Ready and valid come only from registered state, so out_ready never
   // reaches in_ready combinationally.
   assign in_ready  = ~skid_v & ~rst;
   assign out_valid = main_v;
   assign out_data  = main_data;
   assign out_nop   = main_nop;

   assign accept = in_valid & in_ready;
   assign xfer   = main_v & out_ready;

   always_comb begin
      nxt_main_v    = main_v;
      nxt_skid_v    = skid_v;
      nxt_main_nop  = main_nop;
      nxt_skid_nop  = skid_nop;
      nxt_main_data = main_data;
      nxt_skid_data = skid_data;
      if (flush) begin
         nxt_main_v    = 1'b0;
         nxt_skid_v    = 1'b0;
         nxt_main_nop  = 1'b1;
         nxt_skid_nop  = 1'b0;
         nxt_main_data = '0;
         nxt_skid_data = '0;
      end else if (!main_v) begin
         if (accept) begin
            nxt_main_v    = 1'b1;
            nxt_main_nop  = in_nop;
            nxt_main_data = in_data;
         end
      end else if (!skid_v) begin
         if (accept && xfer) begin
            nxt_main_nop  = in_nop;
            nxt_main_data = in_data;
         end else if (accept) begin
            nxt_skid_v    = 1'b1;
            nxt_skid_nop  = in_nop;
            nxt_skid_data = in_data;
         end else if (xfer) begin
            nxt_main_v    = 1'b0;
            nxt_main_nop  = 1'b1;
            nxt_main_data = '0;
         end
      end else if (xfer) begin
         // Skid entry moves up; in_ready reopens next cycle.
         nxt_main_nop  = skid_nop;
         nxt_main_data = skid_data;
         nxt_skid_v    = 1'b0;
         nxt_skid_nop  = 1'b0;
         nxt_skid_data = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v     <= 1'b0;
         skid_v     <= 1'b0;
         main_nop   <= 1'b1;
         skid_nop   <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         main_v    <= nxt_main_v;
         skid_v    <= nxt_skid_v;
         main_nop  <= nxt_main_nop;
         skid_nop  <= nxt_skid_nop;
         main_data <= nxt_main_data;
         skid_data <= nxt_skid_data;
         if (main_v && !out_ready) stall_cnt <= sat_inc(stall_cnt);
         if (xfer && main_nop)     bubble_cnt <= sat_inc(bubble_cnt);
      end
   end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: directed scenarios plus random traffic, compared
// against a FIFO-of-entries reference model (two instances: wide and 2-bit counters).
module tb_id_ex_skid_stage;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_nop, out_ready;
   logic [W-1:0]  in_data;
   logic          in_ready, out_valid, out_nop;
   logic [W-1:0]  out_data;
   logic [15:0]   stall_cnt, bubble_cnt;
   logic          s_in_ready, s_out_valid, s_out_nop;
   logic [W-1:0]  s_out_data;
   logic [1:0]    s_stall_cnt, s_bubble_cnt;

   int checks   = 0;
   int failures = 0;

   logic [W:0]    q[$];
   int unsigned   stall_m, bubble_m;
   bit            model_ok = 1'b0;
   logic [W-1:0]  got[$];

   always #5 clk = ~clk;

   id_ex_skid_stage #(.W(W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_nop(in_nop), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_nop(out_nop), .out_data(out_data),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   id_ex_skid_stage #(.W(W), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_nop(in_nop), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_nop(s_out_nop), .out_data(s_out_data),
      .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_all();
      logic          e_v, e_nop, e_rdy;
      logic [W-1:0]  e_d;
      e_v   = (q.size() > 0);
      e_d   = e_v ? q[0][W-1:0] : '0;
      e_nop = e_v ? q[0][W] : 1'b1;
      e_rdy = (q.size() < 2) && !rst;
      chk("in_ready",     32'(in_ready),     32'(e_rdy));
      chk("out_valid",    32'(out_valid),    32'(e_v));
      chk("out_nop",      32'(out_nop),      32'(e_nop));
      chk("out_data",     out_data,          e_d);
      chk("stall_cnt",    32'(stall_cnt),    sat(stall_m, 65535));
      chk("bubble_cnt",   32'(bubble_cnt),   sat(bubble_m, 65535));
      chk("s_in_ready",   32'(s_in_ready),   32'(e_rdy));
      chk("s_out_data",   s_out_data,        e_d);
      chk("s_stall_cnt",  32'(s_stall_cnt),  sat(stall_m, 3));
      chk("s_bubble_cnt", 32'(s_bubble_cnt), sat(bubble_m, 3));
   endtask

   task automatic model_update();
      bit acc, xf;
      acc = in_valid && (q.size() < 2) && !rst;
      xf  = (q.size() > 0) && out_ready;
      if (rst) begin
         q.delete();
         stall_m  = 0;
         bubble_m = 0;
         model_ok = 1'b1;
      end else begin
         if (q.size() > 0 && !out_ready) stall_m++;
         if (xf && q[0][W]) bubble_m++;
         if (xf) void'(q.pop_front());
         if (flush) q.delete();
         else if (acc) q.push_back({in_nop, in_data});
      end
   endtask

   task automatic cycle();
      #1;
      if (model_ok) check_all();
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic v, input logic nop, input logic [W-1:0] d,
                        input logic ordy, input logic fl, input logic r);
      in_valid  = v;
      in_nop    = v ? nop : 1'bx;
      in_data   = v ? d : 'x;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      cycle();
   endtask

   initial begin
      int unsigned st0;
      int          idx, guard;
      logic [W-1:0] exp_list[$];

      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_nop = 1'b0; in_data = 32'h1; out_ready = 1'b0;

      // Reset with in_valid held high
      drive(1, 0, 32'h1, 0, 0, 1);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      drive(1, 0, 32'h2, 0, 0, 1);
      chk("rst_in_ready2", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_nop", 32'(out_nop), 32'd1);
      drive(0, 0, 0, 1, 0, 0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Streaming
      got.delete();
      drive(1, 0, 32'h11, 1, 0, 0);
      chk("stream_lat", out_data, 32'h11);
      drive(1, 0, 32'h22, 1, 0, 0);
      chk("stream_b2b", out_data, 32'h22);
      drive(1, 0, 32'h33, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      chk("stream_stall", 32'(stall_cnt), 32'd0);
      chk("stream_cnt", 32'(got.size()), 32'd3);

      // Skid: out_ready low for cycles 2..4
      drive(0, 0, 0, 1, 0, 1);
      got.delete(); exp_list.delete();
      for (int k = 0; k < 5; k++) exp_list.push_back(32'hA0 + k);
      idx = 0; guard = 0;
      while ((idx < 5 || q.size() > 0) && guard < 40) begin
         bit acc;
         logic ordy;
         ordy = !(guard >= 1 && guard <= 3);
         acc  = (idx < 5) && (q.size() < 2);
         drive(idx < 5, 0, exp_list[idx < 5 ? idx : 0], ordy, 0, 0);
         if (guard == 1) chk("skid_in_ready_drop", 32'(in_ready), 32'd0);
         if (guard == 2) chk("skid_frozen", out_data, 32'hA0);
         if (acc) idx++;
         guard++;
      end
      chk("skid_bound", 32'(guard < 40), 32'd1);
      chk("skid_stall", 32'(stall_cnt), 32'd3);
      chk("skid_count", 32'(got.size()), 32'd5);
      for (int k = 0; k < 5 && k < got.size(); k++) chk("skid_order", got[k], exp_list[k]);

      // Flush in TWO
      drive(1, 0, 32'h5, 0, 0, 0);
      drive(1, 0, 32'h6, 0, 0, 0);
      st0 = 32'(stall_cnt);
      got.delete();
      drive(1, 0, 32'h7, 0, 1, 0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_data", out_data, 32'd0);
      chk("flush_stall_kept", 32'(stall_cnt), st0 + 1);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      chk("flush_no7", 32'(got.size()), 32'd0);
      // Flush in ONE: xfer completes, the accepted entry is dropped
      drive(1, 0, 32'h8, 1, 0, 0);
      drive(1, 0, 32'h9, 1, 1, 0);
      chk("flush_one_valid", 32'(out_valid), 32'd0);

      // Bubbles and saturation
      drive(0, 0, 0, 1, 0, 1);
      for (int k = 0; k < 5; k++) drive(1, 1, 32'(k), 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      chk("bubble_sat", 32'(s_bubble_cnt), 32'd3);
      chk("bubble_wide", 32'(bubble_cnt), 32'd5);
      drive(1, 0, 32'h42, 0, 0, 0);
      for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0, 0);
      chk("stall_sat", 32'(s_stall_cnt), 32'd3);
      chk("stall_wide", 32'(stall_cnt), 32'd6);

      // Reset mid-operation in TWO
      drive(1, 0, 32'h43, 0, 0, 0);
      chk("pre_rst_two", 32'(in_ready), 32'd0);
      drive(1, 0, 32'h44, 0, 0, 1);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
      drive(1, 0, 32'h9, 1, 0, 0);
      chk("mid_rst_next", out_data, 32'h9);
      chk("mid_rst_next_v", 32'(out_valid), 32'd1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom,
               $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
               $urandom_range(0, 49) == 0);
      end
      drive(0, 0, 0, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised successor to the ID/EX pipeline register. It carries an arbitrary-width decoded-instruction payload plus a nop flag between two pipeline stages.
- Replaces the single stop/clr register with a valid/ready handshake and a 2-entry skid buffer. A downstream stall therefore reaches upstream one cycle later without losing data.
- Adds synchronous flush and saturating stall/bubble performance counters.
- Drop-in between decode and execute, or any stage pair in the core.

Parameters:
W, 32, payload width in bits (packed decoded fields: regs, imm, pc, control bits); legal range 1..512
CNT_W, 16, width of each performance counter; legal range 1..32

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous flush: discard all held and incoming entries
in_valid  input  1  upstream presents an entry
in_ready  output  1  stage can accept an entry this cycle
in_nop  input  1  entry is a bubble/nop
in_data  input  W  entry payload
out_valid  output  1  stage presents an entry downstream
out_ready  input  1  downstream accepts this cycle
out_nop  output  1  nop flag of the presented entry
out_data  output  W  presented payload
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  output  CNT_W  downstream transfers with out_nop=1

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Definitions:
  - accept = in_valid & in_ready
  - xfer = out_valid & out_ready
- Storage is a main register (drives out_*) plus a skid register.
- State is encoded by main_v and skid_v: EMPTY (0,0), ONE (1,0), TWO (1,1). The combination (0,1) is illegal and never reached.
- Output assignments:
  - out_valid = main_v
  - in_ready = ~skid_v & ~rst
  - Both are registered-state-derived. No combinational path from out_ready to in_ready.
- Empty-main values: when main_v=0, out_data = 0 and out_nop = 1. The main register is cleared whenever it becomes empty.
- Transitions (no rst, no flush):
  - EMPTY: accept -> ONE, main <= in. Otherwise stay.
  - ONE, accept & xfer: stay ONE, main <= in.
  - ONE, accept & ~xfer: -> TWO, skid <= in, main holds.
  - ONE, ~accept & xfer: -> EMPTY, main cleared.
  - ONE, neither: hold.
  - TWO: in_ready=0, so no accept. xfer -> ONE, main <= skid, skid cleared. Otherwise hold.
- Latency: 1 cycle from accept in EMPTY to out_valid. Sustained throughput is 1 entry/cycle when out_ready is held high.
- Data held in main must not change while out_valid=1 and out_ready=0.
- Flush (rst=0, flush=1):
  - Next state is EMPTY; both registers are cleared.
  - An entry accepted in the flush cycle is discarded. Upstream sees the handshake complete.
  - An xfer in the flush cycle still completes downstream.
  - Counters are not cleared by flush.
- Reset (rst=1):
  - Overrides flush and all handshakes, including mid-operation with TWO occupied.
  - Next state EMPTY, out_data=0, out_nop=1, out_valid=0, stall_cnt=0, bubble_cnt=0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
- stall_cnt: +1 each cycle with out_valid & ~out_ready (including flush cycles). Saturates at 2^CNT_W-1 and does not wrap.
- bubble_cnt: +1 on each xfer with out_nop=1. Saturates the same way.
- nop entries are otherwise ordinary entries: they occupy storage and obey the handshake.
- X on in_data/in_nop while in_valid=0 must never propagate to out_*.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> in_ready=0 during rst. After rst, out_valid=0, out_data=0, out_nop=1, counters 0, in_ready=1.
- Streaming, W=32: send 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_data 0x11,0x22,0x33 appear 1 cycle later, back-to-back, in_ready stays 1, stall_cnt=0.
- Skid, W=32: stream 0xA0..0xA4 with out_ready=0 from cycle 2 for 3 cycles, then 1.
  - in_ready drops after the second entry is held.
  - out_data frozen at 0xA0 during the stall.
  - stall_cnt=3.
  - All five values are delivered in order with none lost or duplicated.
- Flush in TWO: fill main=0x5, skid=0x6, then flush=1 with in_valid=1 data=0x7 -> next cycle EMPTY, out_valid=0, out_data=0. 0x7 is never output. stall_cnt is retained.
- Bubbles and saturation, CNT_W=2: transfer 5 entries with in_nop=1 -> bubble_cnt reads 1,2,3,3,3. Then hold out_ready=0 for 6 cycles with an entry valid -> stall_cnt sticks at 3.
- Reset mid-operation: in TWO with out_ready=0, pulse rst for 1 cycle -> EMPTY, counters 0. The next accepted entry 0x9 appears on out_data 1 cycle later.
